// File: rtl/game_pkg.sv
// Shared constants and state encoding for the guess-number game blocks.
// The button-capture block and the sequence player both import this package.
package game_pkg;

    localparam int MAX_LEN     = 7;
    localparam int MIN_LEN     = 4;
    localparam int NUM_BUTTONS = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ON,
        GAP,
        DONE
    } player_state_t;

endpackage

// File: rtl/seq_code_check.sv
// Validates a latched code: the length must be in range, every used position
// must name exactly one button, and every unused position must be empty.
module seq_code_check
    import game_pkg::*;
(
    input  logic [0:MAX_LEN-1] mask1,
    input  logic [0:MAX_LEN-1] mask2,
    input  logic [0:MAX_LEN-1] mask3,
    input  logic [0:MAX_LEN-1] mask4,
    input  logic [2:0]         len,
    output logic               valid
);

    logic [2:0] ones;

    always_comb begin
        ones  = '0;
        valid = (int'(len) >= MIN_LEN) && (int'(len) <= MAX_LEN);
        for (int p = 0; p < MAX_LEN; p++) begin
            ones = 3'(mask1[p]) + 3'(mask2[p]) + 3'(mask3[p]) + 3'(mask4[p]);
            if (p < int'(len)) begin
                if (ones != 3'd1) valid = 1'b0;
            end else begin
                if (ones != 3'd0) valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Replays a stored guess-number code one symbol at a time on four indicator
// outputs, with a fixed on-time and all-off gap per symbol.
module sequence_player
    import game_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [0:MAX_LEN-1] code1,
    input  logic [0:MAX_LEN-1] code2,
    input  logic [0:MAX_LEN-1] code3,
    input  logic [0:MAX_LEN-1] code4,
    input  logic [2:0]         len,
    output logic               o1,
    output logic               o2,
    output logic               o3,
    output logic               o4,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int TIMER_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);

    player_state_t state, next_state;

    logic [0:MAX_LEN-1] mask1, mask2, mask3, mask4;
    logic [2:0]         len_q;
    logic [2:0]         pos, pos_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [3:0]         led, led_next;
    logic               busy_next, done_next, err_next;
    logic               code_valid;
    logic               last_symbol;
    logic               accept;

    seq_code_check u_check (
        .mask1 (mask1),
        .mask2 (mask2),
        .mask3 (mask3),
        .mask4 (mask4),
        .len   (len_q),
        .valid (code_valid)
    );

    // Bit 0 of the returned vector drives o1, bit 3 drives o4.
    function automatic logic [3:0] symbol_at(input logic [2:0] p);
        return {mask4[p], mask3[p], mask2[p], mask1[p]};
    endfunction

    assign accept      = (state == IDLE) && start && !stop;
    assign last_symbol = (pos >= len_q - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mask1 <= '0;
            mask2 <= '0;
            mask3 <= '0;
            mask4 <= '0;
            len_q <= '0;
            pos   <= '0;
            timer <= '0;
            led   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            pos   <= pos_next;
            timer <= timer_next;
            led   <= led_next;
            busy  <= busy_next;
            done  <= done_next;
            err   <= err_next;
            if (accept) begin
                mask1 <= code1;
                mask2 <= code2;
                mask3 <= code3;
                mask4 <= code4;
                len_q <= len;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = CHECK;
            CHECK: next_state = (!stop && code_valid) ? ON : IDLE;
            ON: begin
                if (stop)                  next_state = IDLE;
                else if (timer == ON_LAST) next_state = GAP;
            end
            GAP: begin
                if (stop)                   next_state = IDLE;
                else if (timer == OFF_LAST) next_state = last_symbol ? DONE : ON;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next-cycle values for the registered outputs and counters.
    always_comb begin
        pos_next   = '0;
        timer_next = '0;
        if ((state == ON || state == GAP) && next_state == state) begin
            timer_next = timer + 1'b1;
        end
        if (next_state == ON) begin
            if (state == GAP)     pos_next = pos + 3'd1;
            else if (state == ON) pos_next = pos;
        end else if (next_state == GAP) begin
            pos_next = pos;
        end
        led_next  = (next_state == ON) ? symbol_at(pos_next) : 4'b0000;
        busy_next = (next_state == CHECK) || (next_state == ON) || (next_state == GAP);
        done_next = (next_state == DONE);
        err_next  = (state == CHECK) && !stop && !code_valid;
    end

    assign o1 = led[0];
    assign o2 = led[1];
    assign o3 = led[2];
    assign o4 = led[3];

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Transmit-side counterpart of the button-capture block in the guess-number game.
- Takes a stored code and replays it, one symbol per step, on four indicator outputs, in the same format the capture block produces.
- Code format: four 7-bit position masks plus a length; bit p of maskK set means symbol at position p is button K.
- Sits between the secret-code store and the LED/indicator drivers; used to show the secret after a round or to demo a sequence.

Parameters:
- MAX_LEN, 7, maximum sequence length (mask width).
- MIN_LEN, 4, minimum accepted length; matches the capture rule that enter needs at least 4 symbols.
- ON_CYCLES, 4, clock cycles each symbol is driven (>=1).
- OFF_CYCLES, 2, clock cycles of all-off gap after each symbol (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin playback; sampled only in IDLE.
- stop  input  1  abort playback; sampled every cycle.
- code1  input  [0:MAX_LEN-1]  position mask for button 1; bit 0 is the first symbol.
- code2  input  [0:MAX_LEN-1]  position mask for button 2.
- code3  input  [0:MAX_LEN-1]  position mask for button 3.
- code4  input  [0:MAX_LEN-1]  position mask for button 4.
- len  input  3  number of symbols, valid range MIN_LEN..MAX_LEN.
- o1  output  1  indicator for button 1 (registered); o2..o4 likewise, 1 bit each.
- busy  output  1  high from start acceptance until done or abort.
- done  output  1  one-cycle pulse after the last gap.
- err  output  1  one-cycle pulse when the latched code is rejected.

Behaviour:
- Reset: state IDLE; o1..o4, busy, done and err all 0; position and timer counters 0; latched code cleared. Reset overrides every other input.
- State IDLE:
  - If start=1 and stop=0 at edge N, latch code1..code4 and len, set busy=1 and go to CHECK.
  - start while not in IDLE is ignored. If start and stop are both high in IDLE, stop wins and nothing happens.
- State CHECK (one cycle): the code is valid only if all of these hold:
  - MIN_LEN <= len <= MAX_LEN.
  - Every position p < len has exactly one bit set across code1[p]..code4[p].
  - Every position p >= len has no bits set.
  - Valid at edge N+1: go to ON with pos=0, timer=0, and o1..o4 = code1[0]..code4[0], visible from edge N+1.
  - Invalid at edge N+1: err=1 for one cycle, busy=0, return to IDLE, outputs stay 0.
- State ON: hold the outputs for exactly ON_CYCLES cycles, then clear o1..o4 and go to GAP.
- State GAP: outputs 0 for exactly OFF_CYCLES cycles.
  - If pos < len-1: increment pos, drive the next symbol, go to ON.
  - Otherwise go to DONE.
- State DONE (one cycle): done=1, busy=0, then IDLE. Total busy time for length L is 1 + L*(ON_CYCLES+OFF_CYCLES) cycles.
- stop in CHECK, ON or GAP:
  - Next edge: o1..o4=0, busy=0, IDLE; no done, no err.
  - stop in DONE is ignored; done still pulses.
- At most one output high at any time. Outputs are never combinationally derived from the inputs.
- Input changes after latching do not affect the current playback.
- Counter widths:
  - pos: 3 bits; it never wraps because it stops at len-1.
  - timer: clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits, cleared on every state entry.

Decomposition:
- Shared package game_pkg holds MAX_LEN, MIN_LEN, the button-count constant (4) and the player state enum (IDLE, CHECK, ON, GAP, DONE).
- The capture block also uses MAX_LEN and MIN_LEN from this package.
- One sub-module, seq_code_check: takes the latched masks and len and outputs a valid flag. It is instantiated once; the FSM registers its result in CHECK.

Test Plan:
- Sequence 1,3,4,2 with len=4: code1=1000000, code2=0001000, code3=0100000, code4=0010000; start pulse. Expect o1, o3, o4, o2 each high for 4 cycles with 2-cycle gaps, busy for 25 cycles, done pulse once, err=0.
- Sequence 1,3,4 with len=3: same masks but code2=0. Expect err pulse 2 cycles after start; busy high exactly 1 cycle; no output activity.
- Two buttons set at position 0 (code1=code2=1000000, rest valid, len=4). Expect err pulse and return to IDLE.
- len=7 sequence 4,4,4,4,4,4,4 (code4=1111111): o4 pulses 7 times with gaps; total busy 43 cycles; done pulses.
- stop asserted during the 2nd ON period. Expect outputs 0 and busy 0 on the next edge, no done; a following start replays from symbol 0.
- rst asserted mid-GAP. Expect all outputs 0 next cycle; start pulses during playback are ignored, and simultaneous start+stop in IDLE produces no activity.
